per2axi_res_channel: RTL

//  Response path of the peripheral-to-AXI bridge. Accepts AXI4 R and B responses from the AXI

---
 rtl/per2axi_res_channel.sv | 121 ++++++++++++
 1 files changed

// File: rtl/per2axi_res_channel.sv
// Response path of the peripheral-to-AXI bridge: merges AXI R and B
// responses into single-cycle 32-bit peripheral response pulses.
module per2axi_res_channel #(
    parameter int PER_ID_WIDTH   = 8,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 3,
    parameter int AXI_USER_WIDTH = 6
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    output logic                      per_slave_r_valid_o,
    output logic                      per_slave_r_opc_o,
    output logic [PER_ID_WIDTH-1:0]   per_slave_r_id_o,
    output logic [31:0]               per_slave_r_rdata_o,
    input  logic                      axi_master_r_valid_i,
    input  logic [AXI_DATA_WIDTH-1:0] axi_master_r_data_i,
    input  logic [1:0]                axi_master_r_resp_i,
    input  logic                      axi_master_r_last_i,
    input  logic [AXI_ID_WIDTH-1:0]   axi_master_r_id_i,
    input  logic [AXI_USER_WIDTH-1:0] axi_master_r_user_i,
    output logic                      axi_master_r_ready_o,
    input  logic                      axi_master_b_valid_i,
    input  logic [1:0]                axi_master_b_resp_i,
    input  logic [AXI_ID_WIDTH-1:0]   axi_master_b_id_i,
    input  logic [AXI_USER_WIDTH-1:0] axi_master_b_user_i,
    output logic                      axi_master_b_ready_o,
    input  logic                      trans_req_i,
    input  logic [AXI_ID_WIDTH-1:0]   trans_id_i,
    input  logic [AXI_ADDR_WIDTH-1:0] trans_add_i
);

    localparam int NID = 2**AXI_ID_WIDTH;

    logic [NID-1:0]          r_align;
    logic [NID-1:0]          r_err;
    logic                    r_prio_b;
    logic                    r_valid;
    logic                    r_opc;
    logic [PER_ID_WIDTH-1:0] r_id;
    logic [31:0]             r_rdata;

    logic w_gnt_r;
    logic w_gnt_b;
    logic w_unused;

    // r_prio_b set means B wins the next tie; ready is gated by reset
    assign w_gnt_r = rst_ni & axi_master_r_valid_i
                   & (~axi_master_b_valid_i | ~r_prio_b);
    assign w_gnt_b = rst_ni & axi_master_b_valid_i
                   & (~axi_master_r_valid_i | r_prio_b);

    assign axi_master_r_ready_o = w_gnt_r;
    assign axi_master_b_ready_o = w_gnt_b;

    assign per_slave_r_valid_o = r_valid;
    assign per_slave_r_opc_o   = r_opc;
    assign per_slave_r_id_o    = r_id;
    assign per_slave_r_rdata_o = r_rdata;

    assign w_unused = ^{axi_master_r_user_i, axi_master_b_user_i, trans_add_i};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_align  <= '0;
            r_err    <= '0;
            r_prio_b <= 1'b0;
            r_valid  <= 1'b0;
            r_opc    <= 1'b0;
            r_id     <= '0;
            r_rdata  <= '0;
        end else begin
            r_valid <= w_gnt_b | (w_gnt_r & axi_master_r_last_i);
            if (w_gnt_r | w_gnt_b)
                r_prio_b <= w_gnt_r;
            if (trans_req_i)
                r_align[trans_id_i] <= trans_add_i[2];
            if (w_gnt_r) begin
                if (axi_master_r_last_i) begin
                    r_err[axi_master_r_id_i] <= 1'b0;
                    r_opc <= axi_master_r_resp_i[1] | r_err[axi_master_r_id_i];
                    r_id  <= PER_ID_WIDTH'(1) << axi_master_r_id_i;
                    r_rdata <= r_align[axi_master_r_id_i]
                             ? axi_master_r_data_i[63:32]
                             : axi_master_r_data_i[31:0];
                end else begin
                    r_err[axi_master_r_id_i] <= r_err[axi_master_r_id_i]
                                              | axi_master_r_resp_i[1];
                end
            end
            if (w_gnt_b) begin
                r_opc   <= axi_master_b_resp_i[1];
                r_id    <= PER_ID_WIDTH'(1) << axi_master_b_id_i;
                r_rdata <= '0;
            end
        end
    end

`ifndef SYNTHESIS
    logic [NID-1:0] r_seen;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            r_seen <= '0;
        else if (trans_req_i)
            r_seen[trans_id_i] <= 1'b1;
    end

    always @(posedge clk_i) begin
        if (rst_ni && w_gnt_r)
            assert (r_seen[axi_master_r_id_i] ||
                    (trans_req_i && trans_id_i == axi_master_r_id_i))
            else $error("R response for unrequested id %0d", axi_master_r_id_i);
        if (rst_ni && w_gnt_b)
            assert (r_seen[axi_master_b_id_i] ||
                    (trans_req_i && trans_id_i == axi_master_b_id_i))
            else $error("B response for unrequested id %0d", axi_master_b_id_i);
    end
`endif

endmodule
